cmd_reg_bank: RTL

//  Parametrised command register bank between the host command decoder and the ADC/DDS cores.

---
 rtl/cmd_reg_pkg.sv | 61 ++++++
 rtl/dds_ch_regs.sv | 54 +++++
 rtl/cmd_reg_bank.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cmd_reg_pkg.sv
// Shared address map, field offsets and decoder for the command register bank.
// Imported by cmd_reg_bank and dds_ch_regs.
package cmd_reg_pkg;

    localparam logic [7:0] A_RESTART  = 8'h00;
    localparam logic [7:0] A_CHAN_SEL = 8'h01;
    localparam logic [7:0] A_DATA_NUM = 8'h02;
    localparam logic [7:0] A_SPEED    = 8'h03;
    localparam logic [7:0] A_COMMIT   = 8'h04;
    localparam logic [7:0] A_DDS_BASE = 8'h10;

    localparam int unsigned DDS_STRIDE = 4;

    localparam logic [1:0] F_WAVE = 2'd0;
    localparam logic [1:0] F_FTW  = 2'd1;
    localparam logic [1:0] F_POW  = 2'd2;

    localparam int WAVE_W = 3;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } hold_state_e;

    typedef struct packed {
        logic       restart;
        logic       chsel;
        logic       dnum;
        logic       speed;
        logic       commit;
        logic       dds;
        logic       err;
        logic [2:0] ch;
        logic [1:0] fld;
    } dec_t;

    function automatic dec_t decode(input int unsigned addr,
                                    input int unsigned n_dds);
        int unsigned off;
        dec_t        d;
        d   = '0;
        off = addr - 32'(A_DDS_BASE);
        unique case (1'b1)
            addr == 32'(A_RESTART):  d.restart = 1'b1;
            addr == 32'(A_CHAN_SEL): d.chsel   = 1'b1;
            addr == 32'(A_DATA_NUM): d.dnum    = 1'b1;
            addr == 32'(A_SPEED):    d.speed   = 1'b1;
            addr == 32'(A_COMMIT):   d.commit  = 1'b1;
            (addr >= 32'(A_DDS_BASE)) &&
            (off / DDS_STRIDE < n_dds) &&
            (off % DDS_STRIDE != 32'd3): begin
                d.dds = 1'b1;
                d.ch  = 3'(off / DDS_STRIDE);
                d.fld = 2'(off % DDS_STRIDE);
            end
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dds_ch_regs.sv
// One DDS channel: shadow WAVE/FTW/POW registers and the active copy.
// Active values move only on commit, together with a one-cycle restart strobe.
module dds_ch_regs
    import cmd_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PHASE_W = 16
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               wave_we_i,
    input  logic               ftw_we_i,
    input  logic               pow_we_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic               commit_i,
    output logic [WAVE_W-1:0]  wave_o,
    output logic [DATA_W-1:0]  ftw_o,
    output logic [PHASE_W-1:0] pow_o,
    output logic               restart_o
);

    logic [WAVE_W-1:0]  wave_sh_q, wave_q;
    logic [DATA_W-1:0]  ftw_sh_q, ftw_q;
    logic [PHASE_W-1:0] pow_sh_q, pow_q;
    logic               restart_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wave_sh_q <= '0;
            ftw_sh_q  <= '0;
            pow_sh_q  <= '0;
            wave_q    <= '0;
            ftw_q     <= '0;
            pow_q     <= '0;
            restart_q <= 1'b0;
        end else begin
            if (wave_we_i) wave_sh_q <= wdata_i[WAVE_W-1:0];
            if (ftw_we_i)  ftw_sh_q  <= wdata_i;
            if (pow_we_i)  pow_sh_q  <= wdata_i[PHASE_W-1:0];
            restart_q <= commit_i;
            if (commit_i) begin
                wave_q <= wave_sh_q;
                ftw_q  <= ftw_sh_q;
                pow_q  <= pow_sh_q;
            end
        end
    end

    assign wave_o    = wave_q;
    assign ftw_o     = ftw_q;
    assign pow_o     = pow_q;
    assign restart_o = restart_q;

endmodule

// File: rtl/cmd_reg_bank.sv
// Command register bank: ADC registers, NUM_DDS shadowed DDS channels,
// commit hold-off, registered readback and unmapped-address error reporting.
module cmd_reg_bank
    import cmd_reg_pkg::*;
#(
    parameter int         NUM_DDS   = 2,
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 8,
    parameter int         PHASE_W   = 16,
    parameter int         HOLD_CYC  = 4,
    parameter logic [7:0] CHSEL_RST = 8'hFF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_data,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_err,
    output logic                        cmd_err,
    output logic [7:0]                  err_cnt,
    output logic [7:0]                  chan_sel,
    output logic [DATA_W-1:0]           data_num,
    output logic [DATA_W-1:0]           adc_speed,
    output logic                        adc_restart,
    output logic [NUM_DDS-1:0]          dds_restart,
    output logic [WAVE_W*NUM_DDS-1:0]   dds_wave_sel,
    output logic [DATA_W*NUM_DDS-1:0]   dds_ftw,
    output logic [PHASE_W*NUM_DDS-1:0]  dds_pow
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    hold_state_e        state_q;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic               cmd_ready_q;
    logic [7:0]         chan_sel_q;
    logic [DATA_W-1:0]  data_num_q, adc_speed_q;
    logic               adc_restart_q, cmd_err_q;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               rd_valid_q, rd_err_q;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic [WAVE_W-1:0]  wave_a [NUM_DDS];
    logic [DATA_W-1:0]  ftw_a  [NUM_DDS];
    logic [PHASE_W-1:0] pow_a  [NUM_DDS];

    logic wr_acc;
    dec_t wdec, rdec;

    assign wr_acc = cmd_valid & cmd_ready_q;
    assign wdec   = decode(32'(cmd_addr), NUM_DDS);
    assign rdec   = decode(32'(rd_addr), NUM_DDS);

    assign err_cnt_d = (wr_acc && wdec.err && err_cnt_q != 8'hFF)
                     ? err_cnt_q + 8'd1 : err_cnt_q;

    // ready drops for exactly HOLD_CYC cycles after each accepted commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (wr_acc && wdec.commit) begin
                        state_q     <= S_HOLD;
                        hold_cnt_q  <= CNT_W'(HOLD_CYC - 1);
                        cmd_ready_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chan_sel_q    <= CHSEL_RST;
            data_num_q    <= '0;
            adc_speed_q   <= '0;
            adc_restart_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            err_cnt_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_err_q      <= 1'b0;
        end else begin
            adc_restart_q <= wr_acc & wdec.restart;
            cmd_err_q     <= wr_acc & wdec.err;
            err_cnt_q     <= err_cnt_d;
            if (wr_acc && wdec.chsel) chan_sel_q  <= cmd_data[7:0];
            if (wr_acc && wdec.dnum)  data_num_q  <= cmd_data;
            if (wr_acc && wdec.speed) adc_speed_q <= cmd_data;
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_data_d;
                rd_err_q  <= rdec.err;
            end
        end
    end

    // readback sees active values as they stand before this cycle's write
    always_comb begin
        rd_data_d = '0;
        unique case (1'b1)
            rdec.restart, rdec.commit: rd_data_d = '0;
            rdec.chsel: rd_data_d = DATA_W'(chan_sel_q);
            rdec.dnum:  rd_data_d = data_num_q;
            rdec.speed: rd_data_d = adc_speed_q;
            rdec.dds: begin
                for (int k = 0; k < NUM_DDS; k++) begin
                    if (rdec.ch == 3'(k)) begin
                        unique case (rdec.fld)
                            F_WAVE:  rd_data_d = DATA_W'(wave_a[k]);
                            F_FTW:   rd_data_d = ftw_a[k];
                            F_POW:   rd_data_d = DATA_W'(pow_a[k]);
                            default: rd_data_d = '0;
                        endcase
                    end
                end
            end
            default: rd_data_d = '0;
        endcase
    end

    for (genvar k = 0; k < NUM_DDS; k++) begin : g_ch
        logic sel;
        assign sel = wr_acc && wdec.dds && (wdec.ch == 3'(k));

        dds_ch_regs #(
            .DATA_W  (DATA_W),
            .PHASE_W (PHASE_W)
        ) u_ch (
            .clk_i     (clk),
            .reset_ni  (reset_n),
            .wave_we_i (sel && wdec.fld == F_WAVE),
            .ftw_we_i  (sel && wdec.fld == F_FTW),
            .pow_we_i  (sel && wdec.fld == F_POW),
            .wdata_i   (cmd_data),
            .commit_i  (wr_acc && wdec.commit && cmd_data[k]),
            .wave_o    (wave_a[k]),
            .ftw_o     (ftw_a[k]),
            .pow_o     (pow_a[k]),
            .restart_o (dds_restart[k])
        );

        assign dds_wave_sel[k*WAVE_W +: WAVE_W] = wave_a[k];
        assign dds_ftw[k*DATA_W +: DATA_W]      = ftw_a[k];
        assign dds_pow[k*PHASE_W +: PHASE_W]    = pow_a[k];
    end

    assign cmd_ready   = cmd_ready_q;
    assign chan_sel    = chan_sel_q;
    assign data_num    = data_num_q;
    assign adc_speed   = adc_speed_q;
    assign adc_restart = adc_restart_q;
    assign cmd_err     = cmd_err_q;
    assign err_cnt     = err_cnt_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_err      = rd_err_q;

endmodule
